// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares the byte-wide memory port between fetch and load/store, one word as 4 big-endian beats.
// Define MIPS_BUS_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module mips_bus_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [ADDR_W-1:0] address_out,
    output logic              mem_we,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    state_t state_q, state_d;
    logic [1:0] beat_q;
    logic win_data_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0] shift_q, if_rdata_q, d_rdata_q;
    logic data_wins, start, shift_en;
`ifdef MIPS_BUS_ARB_RR_EN
    logic prio_data_q;
    assign data_wins = d_req && (!if_req || prio_data_q);
    always_ff @(posedge clk)
        if (rst) prio_data_q <= 1'b1;
        else if (start) prio_data_q <= !data_wins;
`else
    assign data_wins = d_req;
`endif
    assign start = state_q == IDLE && (if_req || d_req);
    // Writes shift out a byte every beat; reads shift in from beat 1 on, since memory lags one cycle.
    assign shift_en = (state_q == XFER && (we_q || beat_q != 2'd0)) || state_q == TAIL;
    assign address_out = addr_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata = d_rdata_q;
    always_ff @(posedge clk)
        state_q <= rst ? IDLE : state_d;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = start ? XFER : IDLE;
            XFER: state_d = beat_q != 2'd3 ? XFER : we_q ? DONE : TAIL;
            TAIL: state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy     = state_q != IDLE;
        mem_we   = state_q == XFER && we_q;
        data_out = mem_we ? shift_q[31:24] : 8'h00;
        if_ack   = state_q == DONE && !win_data_q;
        d_ack    = state_q == DONE && win_data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= 2'd0;
            win_data_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            shift_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (start) begin
                win_data_q <= data_wins;
                we_q       <= data_wins && d_we;
                addr_q     <= (data_wins ? d_addr : if_addr) & WORD_MASK;
                shift_q    <= d_wdata;
                beat_q     <= 2'd0;
            end
            if (state_q == XFER) begin
                beat_q <= beat_q + 2'd1;
                if (beat_q != 2'd3) addr_q[1:0] <= beat_q + 2'd1;
            end
            if (shift_en) shift_q <= {shift_q[23:0], data_in};
            if (state_q == TAIL && win_data_q) d_rdata_q <= {shift_q[23:0], data_in};
            if (state_q == TAIL && !win_data_q) if_rdata_q <= {shift_q[23:0], data_in};
        end
    end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed transfers against a byte memory model, checked by a cycle-stamped scoreboard.
module tb_mips_bus_arbiter;
    localparam int K_BEAT = 0, K_BUSY = 1, K_ZERO = 2, K_DRD = 3;
    typedef struct {
        int cyc;
        int kind;
        logic [7:0] a;
        logic we;
        logic [7:0] d;
        logic [31:0] w;
    } ev_t;
    typedef struct {
        int cyc;
        bit is_d;
        bit rd;
        logic [31:0] w;
    } ack_t;
    logic clk = 1'b0, rst;
    logic if_req, if_ack, d_req, d_we, d_ack, mem_we, busy;
    logic [7:0] if_addr, d_addr, data_in, data_out, address_out, rd_q;
    logic [31:0] if_rdata, d_rdata, d_wdata;
    logic [7:0] mem [256];
    int cyc = 0, n_vec = 0, n_err = 0, c;
    ev_t evq[$];
    ack_t ackq[$];
    ev_t e;
    ack_t a;
    mips_bus_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .data_in(data_in), .data_out(data_out), .address_out(address_out), .mem_we(mem_we), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign data_in = rd_q;
    always @(posedge clk)
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} <= 32'h12345678;
            {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} <= 32'hA1B2C3D4;
            {mem[8'h44], mem[8'h45], mem[8'h46], mem[8'h47]} <= 32'hCAFE005A;
            rd_q <= 8'h00;
        end else begin
            rd_q <= mem[address_out];
            if (mem_we) mem[address_out] <= data_out;
        end
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask
    function automatic ev_t mk(input int cy, input int k, input logic [7:0] ad, input logic we,
                               input logic [7:0] d, input logic [31:0] w);
        ev_t r;
        r.cyc = cy; r.kind = k; r.a = ad; r.we = we; r.d = d; r.w = w;
        return r;
    endfunction
    function automatic void push_ev(input ev_t x);
        int i = 0;
        while (i < evq.size() && evq[i].cyc <= x.cyc) i++;
        evq.insert(i, x);
    endfunction
    function automatic void push_ack(input ack_t x);
        int i = 0;
        while (i < ackq.size() && ackq[i].cyc <= x.cyc) i++;
        ackq.insert(i, x);
    endfunction
    // Expected beats and ack for a transfer granted in IDLE cycle g.
    function automatic void push_xfer(input bit is_d, input bit we, input logic [7:0] ad,
                                      input logic [31:0] wd, input logic [31:0] rw, input int g);
        ack_t x;
        for (int b = 0; b < 4; b++)
            push_ev(mk(g + 1 + b, K_BEAT, (ad & 8'hFC) | 8'(b), we, we ? 8'(wd >> (24 - 8 * b)) : 8'h00, 0));
        x.cyc = g + (we ? 5 : 6); x.is_d = is_d; x.rd = !we; x.w = rw;
        push_ack(x);
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_drop(input bit is_d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_ack : if_ack) && n < 60);
        n_vec++;
        if (!(is_d ? d_ack : if_ack)) begin
            n_err++;
            $display("FAIL ack_timeout port_d=%0d: got no ack within %0d cycles, required one", is_d, n);
        end
        tick();
        if (is_d) d_req = 1'b0;
        else if_req = 1'b0;
    endtask
    task automatic req(input bit is_d, input bit we, input logic [7:0] ad, input logic [31:0] wd,
                       input logic [31:0] rw, input int g);
        push_xfer(is_d, we, ad, wd, rw, g);
        if (is_d) begin
            d_we = we; d_addr = ad; d_wdata = wd; d_req = 1'b1;
        end else begin
            if_addr = ad; if_req = 1'b1;
        end
        wait_drop(is_d);
    endtask
    always @(negedge clk) begin
        if (if_ack || d_ack) begin
            if (ackq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_ack cycle %0d: got if_ack=%b d_ack=%b expected none", cyc, if_ack, d_ack);
            end else begin
                a = ackq.pop_front();
                check("ack_cycle", cyc, a.cyc);
                check("ack_port", {if_ack, d_ack}, a.is_d ? 2'b01 : 2'b10);
                if (a.rd) check(a.is_d ? "d_rdata_ack" : "if_rdata_ack", a.is_d ? d_rdata : if_rdata, a.w);
            end
        end
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
            e = evq.pop_front();
            case (e.kind)
                K_BEAT: begin
                    check("address_out", address_out, e.a);
                    check("mem_we", mem_we, e.we);
                    check("data_out", data_out, e.d);
                end
                K_BUSY: check("busy", busy, e.we);
                K_ZERO: begin
                    check("rst_outs", {address_out, data_out, mem_we, if_ack, d_ack, busy}, 0);
                    check("rst_rdata", if_rdata | d_rdata, 0);
                end
                default: check("d_rdata_hold", d_rdata, e.w);
            endcase
        end
    end
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 8'h00; d_addr = 8'h00; d_wdata = 32'h0;
        repeat (2) tick();
        push_ev(mk(cyc, K_ZERO, 0, 0, 0, 0));
        rst = 1'b0;
        tick();
        req(0, 0, 8'h42, 0, 32'h12345678, cyc);
        tick();
        c = cyc;
        push_xfer(1, 0, 8'h21, 0, 32'hA1B2C3D4, c);
        push_ev(mk(c + 7, K_DRD, 0, 0, 0, 32'hA1B2C3D4));
        d_we = 1'b0; d_addr = 8'h21; d_req = 1'b1;
        repeat (2) tick();
        d_req = 1'b0;
        repeat (6) tick();
        for (int s = 0; s < 2; s++) begin
            c = cyc;
            for (int k = 1; k <= 5; k++) push_ev(mk(c + k, K_BUSY, 0, 1'b1, 0, 0));
            push_ev(mk(c + 6, K_BUSY, 0, 1'b0, 0, 0));
            push_ev(mk(c + 6, K_DRD, 0, 0, 0, 32'hA1B2C3D4));
            if (s == 0) req(1, 1, 8'h8E, 32'hDEADBEEF, 0, c);
            else req(1, 1, 8'h90, 32'h01020304, 0, c);
        end
        tick();
        req(0, 0, 8'h8C, 0, 32'hDEADBEEF, cyc);
        tick();
        c = cyc;
        fork
            begin
`ifdef MIPS_BUS_ARB_RR_EN
                req(1, 0, 8'h20, 0, 32'hA1B2C3D4, c);
                req(1, 0, 8'h90, 0, 32'h01020304, c + 14);
`else
                req(1, 0, 8'h20, 0, 32'hA1B2C3D4, c);
                req(1, 0, 8'h90, 0, 32'h01020304, c + 7);
`endif
            end
            begin
`ifdef MIPS_BUS_ARB_RR_EN
                req(0, 0, 8'h40, 0, 32'h12345678, c + 7);
                req(0, 0, 8'h8C, 0, 32'hDEADBEEF, c + 21);
`else
                req(0, 0, 8'h40, 0, 32'h12345678, c + 14);
                req(0, 0, 8'h8C, 0, 32'hDEADBEEF, c + 21);
`endif
            end
        join
        tick();
        c = cyc;
        push_xfer(0, 0, 8'h44, 0, 32'hCAFE005A, c + 4);
        push_ev(mk(c + 4, K_ZERO, 0, 0, 0, 0));
        if_addr = 8'h44; if_req = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_drop(0);
        repeat (4) tick();
        check("acks_pending", ackq.size(), 0);
        check("events_pending", evq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
